// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared bus widths for the simple processor memory system
package simple_processor_pkg;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between I and D requesters
// One transaction in flight; attributes latched at grant, watchdog aborts a stalled memory.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  timeout_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LP_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LP_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_d;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [CW-1:0]         r_wdog;
    logic                  w_busy;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_timeout;
    logic                  w_done;

    // On a conflict the port that was not served last wins.
    assign w_busy    = (r_state != S_IDLE);
    assign w_grant_i = (r_state == S_IDLE) && imem_req_i && (!dmem_req_i || r_last_d);
    assign w_grant_d = (r_state == S_IDLE) && dmem_req_i && !w_grant_i;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_busy && !mem_ack_i && (r_wdog == LP_LAST);
    assign w_done    = w_busy && (mem_ack_i || w_timeout);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_i) begin
                    w_next_state = S_BUSY_I;
                end else if (w_grant_d) begin
                    w_next_state = S_BUSY_D;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (w_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o    = w_busy;
        imem_ack_o   = (r_state == S_BUSY_I) && w_done;
        dmem_ack_o   = (r_state == S_BUSY_D) && w_done;
        timeout_o    = w_timeout;
        imem_rdata_o = w_timeout ? '0 : mem_rdata_i;
        dmem_rdata_o = w_timeout ? '0 : mem_rdata_i;
    end

    // Attributes are captured only at grant so requester changes never reach the memory mid-transaction.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_last_d    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wdog      <= '0;
        end else if (w_grant_i) begin
            r_last_d    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= imem_addr_i;
            r_mem_wdata <= '0;
            r_wdog      <= '0;
        end else if (w_grant_d) begin
            r_last_d    <= 1'b1;
            r_mem_we    <= dmem_we_i;
            r_mem_addr  <= dmem_addr_i;
            r_mem_wdata <= dmem_wdata_i;
            r_wdog      <= '0;
        end else if (w_busy && !mem_ack_i && (r_wdog != LP_MAX)) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = simple_processor_pkg::ADDR_WIDTH;
    localparam int DW = simple_processor_pkg::DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req, dmem_req, dmem_we, mem_ack;
    logic [AW-1:0] imem_addr, dmem_addr;
    logic [DW-1:0] dmem_wdata, mem_rdata;
    logic [DW-1:0] imem_rdata, dmem_rdata, mem_wdata;
    logic          imem_ack, dmem_ack, mem_req, mem_we, timeout;
    logic [AW-1:0] mem_addr;

    logic          t_imem_req, t_mem_ack;
    logic [DW-1:0] t_imem_rdata, t_dmem_rdata, t_mem_wdata;
    logic          t_imem_ack, t_dmem_ack, t_mem_req, t_mem_we, t_timeout;
    logic [AW-1:0] t_mem_addr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter u_dut (
        .clk_i(clk), .arst_ni(rst_n),
        .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_rdata_o(imem_rdata), .imem_ack_o(imem_ack),
        .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
        .dmem_rdata_o(dmem_rdata), .dmem_ack_o(dmem_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .timeout_o(timeout)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_wd (
        .clk_i(clk), .arst_ni(rst_n),
        .imem_req_i(t_imem_req), .imem_addr_i(32'h0000_0200), .imem_rdata_o(t_imem_rdata), .imem_ack_o(t_imem_ack),
        .dmem_req_i(1'b0), .dmem_we_i(1'b0), .dmem_addr_i(32'h0), .dmem_wdata_i(32'h0),
        .dmem_rdata_o(t_dmem_rdata), .dmem_ack_o(t_dmem_ack),
        .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr), .mem_wdata_o(t_mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(t_mem_ack), .timeout_o(t_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_req = 0; dmem_req = 0; dmem_we = 0; mem_ack = 0;
        imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; mem_rdata = 32'h1111_2222;
        t_imem_req = 0; t_mem_ack = 0;
        tick(); tick();
        settle();
        tests_run++;
        if ({mem_req, mem_we, imem_ack, dmem_ack, timeout} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, imem_ack, dmem_ack, timeout});
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        imem_req = 1; imem_addr = 32'h0000_0100; mem_rdata = 32'hCAFE_0001;
        tick();
        tests_run++;
        if ({mem_req, mem_we, mem_addr, imem_ack} !== {1'b1, 1'b0, 32'h0000_0100, 1'b0}) begin
            tests_failed++;
            $display("FAIL i_grant: got req %b we %b addr %h ack %b expected 1 0 00000100 0", mem_req, mem_we, mem_addr, imem_ack);
        end
        tick();
        mem_ack = 1; settle();
        tests_run++;
        if ({imem_ack, dmem_ack, imem_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
            tests_failed++;
            $display("FAIL i_ack: got iack %b dack %b rdata %h expected 1 0 cafe0001", imem_ack, dmem_ack, imem_rdata);
        end
        tick();
        mem_ack = 0; imem_req = 0; settle();
        tests_run++;
        if ({mem_req, imem_ack} !== 2'b00) begin
            tests_failed++;
            $display("FAIL i_done: got req %b ack %b expected 0 0", mem_req, imem_ack);
        end
        tick();
    endtask

    task automatic test_d_write();
        dmem_req = 1; dmem_we = 1; dmem_addr = 32'h0000_0040; dmem_wdata = 32'h0000_BEEF;
        tick();
        for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, dmem_ack} !== {1'b1, 1'b1, 32'h0000_0040, 32'h0000_BEEF, 1'b0}) begin
                tests_failed++;
                $display("FAIL d_hold[%0d]: got req %b we %b addr %h wdata %h ack %b expected 1 1 00000040 0000beef 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, dmem_ack);
            end
            if (c == 0) tick();
        end
        mem_ack = 1; settle();
        tests_run++;
        if ({dmem_ack, imem_ack} !== 2'b10) begin
            tests_failed++;
            $display("FAIL d_ack: got dack %b iack %b expected 1 0", dmem_ack, imem_ack);
        end
        tick();
        mem_ack = 0; dmem_req = 0; dmem_we = 0; settle();
        tests_run++;
        if ({dmem_ack, mem_req} !== 2'b00) begin
            tests_failed++;
            $display("FAIL d_pulse: got dack %b req %b expected 0 0", dmem_ack, mem_req);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_i;
        rst_n = 0; settle(); rst_n = 1;
        imem_req = 1; dmem_req = 1; dmem_we = 0; mem_ack = 1;
        imem_addr = 32'h0000_0A00; dmem_addr = 32'h0000_0D00;
        for (int k = 0; k < 4; k++) begin
            exp_i = (k % 2 == 0);
            tick();
            tests_run++;
            if ({mem_req, imem_ack, dmem_ack, mem_addr} !== {1'b1, exp_i, !exp_i, exp_i ? 32'h0000_0A00 : 32'h0000_0D00}) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got req %b iack %b dack %b addr %h expected I=%b", k, mem_req, imem_ack, dmem_ack, mem_addr, exp_i);
            end
            tick();
            tests_run++;
            if ({mem_req, imem_ack, dmem_ack} !== 3'b000) begin
                tests_failed++;
                $display("FAIL rr_gap[%0d]: got req %b iack %b dack %b expected 0 0 0", k, mem_req, imem_ack, dmem_ack);
            end
        end
        imem_req = 0; dmem_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        dmem_req = 1; dmem_we = 0; dmem_addr = 32'h0000_0080;
        tick();
        dmem_addr = 32'h0000_0999; dmem_we = 1; dmem_wdata = 32'h5555_5555;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) mem_ack = 1;
            settle();
            tests_run++;
            if ({mem_addr, mem_we, dmem_ack} !== {32'h0000_0080, 1'b0, (c == 5)}) begin
                tests_failed++;
                $display("FAIL hold_cycle[%0d]: got addr %h we %b dack %b expected 00000080 0 %b", c, mem_addr, mem_we, dmem_ack, (c == 5));
            end
            tick();
        end
        mem_ack = 0; dmem_req = 0; dmem_we = 0;
        tick();
    endtask

    task automatic test_timeout();
        mem_rdata = 32'hAAAA_5555;
        t_imem_req = 1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            tests_run++;
            if ({t_mem_req, t_timeout, t_imem_ack, t_imem_rdata} !== {1'b1, (c == 4), (c == 4), (c == 4) ? 32'h0 : 32'hAAAA_5555}) begin
                tests_failed++;
                $display("FAIL wd_cycle[%0d]: got req %b to %b ack %b rdata %h", c, t_mem_req, t_timeout, t_imem_ack, t_imem_rdata);
            end
            tick();
        end
        tests_run++;
        if ({t_mem_req, t_timeout, t_imem_ack} !== 3'b000) begin
            tests_failed++;
            $display("FAIL wd_after: got req %b to %b ack %b expected 0 0 0", t_mem_req, t_timeout, t_imem_ack);
        end
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) t_mem_ack = 1;
            settle();
            if (c == 4) begin
                tests_run++;
                if ({t_timeout, t_imem_ack, t_imem_rdata} !== {1'b0, 1'b1, 32'hAAAA_5555}) begin
                    tests_failed++;
                    $display("FAIL wd_ack_wins: got to %b ack %b rdata %h expected 0 1 aaaa5555", t_timeout, t_imem_ack, t_imem_rdata);
                end
            end
            tick();
        end
        t_mem_ack = 0; t_imem_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        imem_req = 1; imem_addr = 32'h0000_0300;
        tick();
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rm_busy: got req %b expected 1", mem_req);
        end
        #2 rst_n = 0; mem_ack = 1; dmem_req = 1; dmem_addr = 32'h0000_0400;
        #1;
        tests_run++;
        if ({mem_req, imem_ack, dmem_ack} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rm_async: got req %b iack %b dack %b expected 0 0 0", mem_req, imem_ack, dmem_ack);
        end
        mem_ack = 0;
        tick();
        rst_n = 1;
        tick();
        tests_run++;
        if ({mem_req, mem_addr, mem_we} !== {1'b1, 32'h0000_0300, 1'b0}) begin
            tests_failed++;
            $display("FAIL rm_first_i: got req %b addr %h we %b expected 1 00000300 0", mem_req, mem_addr, mem_we);
        end
        imem_req = 0; dmem_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
